mealy_prog_fsm: RTL and testbench
=================================

MEALY_PROG_FSM -- requirements
Module: mealy_prog_fsm

Interface
REQ-001 Parameter SW, default 2, state register width; the machine has 2^SW states.
REQ-002 Parameter IW, default 1, input symbol width.
REQ-003 Parameter OW, default 3, Mealy output width.
REQ-004 Parameter CW, default 8, step counter width.
REQ-005 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 Port reset  input  1  asynchronous, active-high reset.
REQ-007 Port run  input  1  enables state stepping.
REQ-008 Port in_valid  input  1  qualifies in for the current cycle.
REQ-009 Port in  input  IW  input symbol.
REQ-010 Port out  output  OW  Mealy output for current {state,in}.
REQ-011 Port out_valid  output  1  out is meaningful this cycle.
REQ-012 Port state  output  SW  current state register.
REQ-013 Port cfg_we  input  1  table write strobe.
REQ-014 Port cfg_addr  input  SW+IW  table index, formed as {state,in}.
REQ-015 Port cfg_data  input  SW+OW  table entry, formed as {next_state,out}.
REQ-016 Port step_cnt  output  CW  count of accepted transitions.

Function
REQ-017 The block SHALL hold an internal table of 2^(SW+IW) entries of SW+OW bits each, indexed by {state,in}.
REQ-018 out SHALL combinationally equal the out field of table[{state,in}], with zero latency (Mealy).
REQ-019 out_valid SHALL equal run & in_valid combinationally; out SHALL still follow the table when out_valid is 0.
REQ-020 A step SHALL occur on a rising clk edge when run=1 and in_valid=1: state loads the next_state field of table[{state,in}].
REQ-021 Without a step, state SHALL hold.
REQ-022 cfg_we=1 SHALL write cfg_data into table[cfg_addr] on the rising edge; the write is visible on out from the following cycle.
REQ-023 On a simultaneous write and step addressing the same entry, the step and out SHALL use the pre-write contents.
REQ-024 Writes SHALL be permitted whether or not run=1.
REQ-025 step_cnt SHALL increment by 1 on each step and saturate at 2^CW-1 (no wrap).

Reset
REQ-026 While reset=1, state SHALL be 0, step_cnt SHALL be 0, and every table entry SHALL be all-zero; consequently out=0 and next_state=0.
REQ-027 Reset asserted mid-operation SHALL clear state, step_cnt and the table immediately, without waiting for clk; it SHALL also discard any write or step in that cycle.
REQ-028 After reset deassertion, the first step or write SHALL occur on the first rising edge at which its enable is high.

Configuration
REQ-029 Macro MEALY_PROG_FSM_STEPCNT_EN defined: the step counter SHALL be implemented per REQ-025.
REQ-030 Macro MEALY_PROG_FSM_STEPCNT_EN undefined: no counter SHALL be implemented and step_cnt SHALL be tied to 0; all other behaviour is unchanged.

Verification (defaults SW=2, IW=1, OW=3, counter enabled)
REQ-031 Reset scenario: assert reset -> state=0, out=000, step_cnt=0; drive in=1 -> out stays 000.
REQ-032 Load scenario: write the 8 entries with {addr:data} = 000:01_111, 001:10_101, 010:10_001, 011:11_011, 100:11_000, 101:00_100, 110:00_110, 111:00_110.
- Then, with run=0, for each state 0..3 and in 0/1, force the state by stepping from reset as needed.
- Required out per state/in: 0/0 -> 111, 0/1 -> 101, 1/0 -> 001, 1/1 -> 011, 2/0 -> 000, 2/1 -> 100, 3/x -> 110.
REQ-033 Step sequence scenario: from state 0, with run=1 and in_valid=1, apply in = 0,0,1,1 over 4 cycles.
- Required state after each edge: 1, 2, 0, 2.
- Required step_cnt: 4.
REQ-034 Gating scenario: apply run=1 with in_valid=0, then run=0 with in_valid=1, for 3 cycles each -> state and step_cnt unchanged; out_valid=0 throughout.
REQ-035 Write/step collision scenario: in state 0 with in=0, step while simultaneously writing 000:11_010.
- Required: next state=1 (old entry).
- Returning to state 0 with in=0 later shows out=010 and next=3.
REQ-036 Saturation and reset scenario:
- Step 260 times -> step_cnt=255 (saturated).
- Assert reset asynchronously mid-cycle -> step_cnt=0, state=0 and out=000 before the next clk edge.

Source files
------------

// File: rtl/mealy_prog_fsm.sv
// mealy_prog_fsm: programmable Mealy machine with a writable transition/output
// table indexed by {state,in}. Each entry is {next_state,out}.
// Optional feature: define MEALY_PROG_FSM_STEPCNT_EN to build the saturating
// step counter; when undefined, step_cnt is tied to zero.
//
// Handshake: a step is accepted on a rising clk edge when run & in_valid is
// high; out_valid mirrors run & in_valid in the same cycle, while out always
// reflects the table entry for the current {state,in}.
module mealy_prog_fsm #(
  parameter int SW = 2,
  parameter int IW = 1,
  parameter int OW = 3,
  parameter int CW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             in_valid,
  input  logic [IW-1:0]    in,
  output logic [OW-1:0]    out,
  output logic             out_valid,
  output logic [SW-1:0]    state,
  input  logic             cfg_we,
  input  logic [SW+IW-1:0] cfg_addr,
  input  logic [SW+OW-1:0] cfg_data,
  output logic [CW-1:0]    step_cnt
);

  localparam int AW    = SW + IW;
  localparam int DW    = SW + OW;
  localparam int DEPTH = 1 << AW;

  logic [SW-1:0] state_q, state_d;
  logic [DW-1:0] tbl_q [DEPTH];
  logic [DW-1:0] tbl_d [DEPTH];
  logic [DW-1:0] entry;
  logic [SW-1:0] next_state;
  logic          step;

  // Table lookup for the current {state,in}; pre-write contents are used
  // because the table is only updated at the clock edge.
  always_comb begin
    entry      = tbl_q[{state_q, in}];
    next_state = entry[DW-1:OW];
    out        = entry[OW-1:0];
    step       = run & in_valid;
    out_valid  = step;
    state      = state_q;
  end

  // Next-state and table-write computation.
  always_comb begin
    state_d = step ? next_state : state_q;
    for (int i = 0; i < DEPTH; i++) begin
      tbl_d[i] = tbl_q[i];
    end
    if (cfg_we) begin
      tbl_d[cfg_addr] = cfg_data;
    end
  end

  // State register and table storage, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
    end
  end

`ifdef MEALY_PROG_FSM_STEPCNT_EN
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturating count of accepted steps.
  always_comb begin
    cnt_d = cnt_q;
    if (step && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Step counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign step_cnt = cnt_q;
`else
  assign step_cnt = '0;
`endif

endmodule

// File: tb/tb_mealy_prog_fsm.sv
// tb_mealy_prog_fsm: directed bench for mealy_prog_fsm at default parameters.
// Inputs change on the falling edge; outputs are sampled mid-cycle.
module tb_mealy_prog_fsm;

  logic       clk;
  logic       reset;
  logic       run;
  logic       in_valid;
  logic [0:0] in_sym;
  logic [2:0] out_s;
  logic       out_valid;
  logic [1:0] state;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [4:0] cfg_data;
  logic [7:0] step_cnt;

  int pass_cnt;
  int total_cnt;

  // Reference model: table, state and saturating counter.
  logic [4:0] tbl_m [8];
  logic [1:0] model_state;
  logic [7:0] model_cnt;

  mealy_prog_fsm dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .in_valid (in_valid),
    .in       (in_sym),
    .out      (out_s),
    .out_valid(out_valid),
    .state    (state),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .step_cnt (step_cnt)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] exp_cnt();
`ifdef MEALY_PROG_FSM_STEPCNT_EN
    return model_cnt;
`else
    return 8'd0;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) tbl_m[i] = 5'd0;
    model_state = 2'd0;
    model_cnt   = 8'd0;
  endfunction

  function automatic void model_step(input logic [0:0] i);
    logic [4:0] e;
    e = tbl_m[{model_state, i}];
    model_state = e[4:3];
    if (model_cnt != 8'hFF) model_cnt = model_cnt + 8'd1;
  endfunction

  // Driver: one table write spanning one rising edge.
  task automatic write_entry(input logic [2:0] a, input logic [4:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    tbl_m[a] = d;
  endtask

  // Driver: one accepted step spanning one rising edge.
  task automatic do_step(input logic [0:0] i);
    @(negedge clk);
    run = 1'b1; in_valid = 1'b1; in_sym = i;
    @(negedge clk);
    run = 1'b0; in_valid = 1'b0;
    model_step(i);
  endtask

  task automatic load_table();
    logic [4:0] d [8];
    d[0] = 5'b01_111; d[1] = 5'b10_101; d[2] = 5'b10_001; d[3] = 5'b11_011;
    d[4] = 5'b11_000; d[5] = 5'b00_100; d[6] = 5'b00_110; d[7] = 5'b00_110;
    for (int a = 0; a < 8; a++) write_entry(3'(a), d[a]);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; in_valid = 1'b0; in_sym = 1'b0;
    cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 5'd0;
    model_reset();
    #3;
    total_cnt++;
    if (state !== 2'd0) $display("FAIL reset_state actual=%0d expected=0", state);
    else pass_cnt++;
    total_cnt++;
    if (out_s !== 3'b000) $display("FAIL reset_out actual=%b expected=000", out_s);
    else pass_cnt++;
    total_cnt++;
    if (step_cnt !== 8'd0) $display("FAIL reset_step_cnt actual=%0d expected=0", step_cnt);
    else pass_cnt++;
    in_sym = 1'b1;
    #1;
    total_cnt++;
    if (out_s !== 3'b000) $display("FAIL reset_out_in1 actual=%b expected=000", out_s);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid actual=%b expected=0", out_valid);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Checks both input values at the current state with run=0.
  task automatic check_outs(input logic [1:0] s, input logic [2:0] o0, input logic [2:0] o1);
    @(negedge clk);
    run = 1'b0; in_valid = 1'b1;
    total_cnt++;
    if (state !== s) $display("FAIL load_state actual=%0d expected=%0d", state, s);
    else pass_cnt++;
    in_sym = 1'b0; #1;
    total_cnt++;
    if (out_s !== o0) $display("FAIL load_out s%0d/in0 actual=%b expected=%b", s, out_s, o0);
    else pass_cnt++;
    in_sym = 1'b1; #1;
    total_cnt++;
    if (out_s !== o1) $display("FAIL load_out s%0d/in1 actual=%b expected=%b", s, out_s, o1);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL load_out_valid actual=%b expected=0", out_valid);
    else pass_cnt++;
    in_valid = 1'b0;
  endtask

  task automatic test_load();
    load_table();
    check_outs(2'd0, 3'b111, 3'b101);
    do_step(1'b0);
    check_outs(2'd1, 3'b001, 3'b011);
    do_step(1'b0);
    check_outs(2'd2, 3'b000, 3'b100);
    do_step(1'b1);
    do_step(1'b0);
    do_step(1'b1);
    check_outs(2'd3, 3'b110, 3'b110);
  endtask

  task automatic test_step_seq();
    logic [0:0] ins [4];
    logic [1:0] exp_s [4];
    ins[0] = 1'b0; ins[1] = 1'b0; ins[2] = 1'b1; ins[3] = 1'b1;
    exp_s[0] = 2'd1; exp_s[1] = 2'd2; exp_s[2] = 2'd0; exp_s[3] = 2'd2;
    apply_reset();
    load_table();
    @(negedge clk);
    run = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_sym = ins[k];
      @(negedge clk);
      model_step(ins[k]);
      total_cnt++;
      if (state !== exp_s[k]) $display("FAIL seq_state step%0d actual=%0d expected=%0d", k, state, exp_s[k]);
      else pass_cnt++;
    end
    run = 1'b0; in_valid = 1'b0;
    total_cnt++;
`ifdef MEALY_PROG_FSM_STEPCNT_EN
    if (step_cnt !== 8'd4) $display("FAIL seq_step_cnt actual=%0d expected=4", step_cnt);
`else
    if (step_cnt !== 8'd0) $display("FAIL seq_step_cnt actual=%0d expected=0", step_cnt);
`endif
    else pass_cnt++;
  endtask

  task automatic test_gating();
    logic [1:0] s0;
    logic [7:0] c0;
    s0 = state;
    c0 = step_cnt;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      run = (k < 3); in_valid = (k >= 3); in_sym = 1'(k);
      #1;
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL gate_out_valid cyc%0d actual=%b expected=0", k, out_valid);
      else pass_cnt++;
    end
    @(negedge clk);
    run = 1'b0; in_valid = 1'b0;
    total_cnt++;
    if (state !== 2'd2 || state !== s0) $display("FAIL gate_state actual=%0d expected=2", state);
    else pass_cnt++;
    total_cnt++;
    if (step_cnt !== exp_cnt() || step_cnt !== c0) $display("FAIL gate_step_cnt actual=%0d expected=%0d", step_cnt, exp_cnt());
    else pass_cnt++;
  endtask

  task automatic test_collision();
    do_step(1'b1);  // state 2 -> 0
    @(negedge clk);
    run = 1'b1; in_valid = 1'b1; in_sym = 1'b0;
    cfg_we = 1'b1; cfg_addr = 3'b000; cfg_data = 5'b11_010;
    #1;
    total_cnt++;
    if (out_s !== 3'b111) $display("FAIL coll_out_prewrite actual=%b expected=111", out_s);
    else pass_cnt++;
    @(negedge clk);
    run = 1'b0; in_valid = 1'b0; cfg_we = 1'b0;
    model_step(1'b0);
    tbl_m[0] = 5'b11_010;
    total_cnt++;
    if (state !== 2'd1) $display("FAIL coll_next_state actual=%0d expected=1", state);
    else pass_cnt++;
    do_step(1'b1);  // 1 -> 3
    do_step(1'b0);  // 3 -> 0
    @(negedge clk);
    in_sym = 1'b0; #1;
    total_cnt++;
    if (out_s !== 3'b010) $display("FAIL coll_out_new actual=%b expected=010", out_s);
    else pass_cnt++;
    do_step(1'b0);
    total_cnt++;
    if (state !== 2'd3) $display("FAIL coll_next_new actual=%0d expected=3", state);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    @(negedge clk);
    run = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 260; k++) begin
      in_sym = 1'($urandom_range(0, 1));
      @(negedge clk);
      model_step(in_sym);
    end
    run = 1'b0; in_valid = 1'b0;
    total_cnt++;
`ifdef MEALY_PROG_FSM_STEPCNT_EN
    if (step_cnt !== 8'd255) $display("FAIL sat_step_cnt actual=%0d expected=255", step_cnt);
`else
    if (step_cnt !== 8'd0) $display("FAIL sat_step_cnt actual=%0d expected=0", step_cnt);
`endif
    else pass_cnt++;
    total_cnt++;
    if (state !== model_state) $display("FAIL sat_state actual=%0d expected=%0d", state, model_state);
    else pass_cnt++;
    // Reset mid-cycle, with a write and step pending on the next edge.
    @(posedge clk);
    #2;
    run = 1'b1; in_valid = 1'b1; in_sym = 1'b0;
    cfg_we = 1'b1; cfg_addr = 3'b000; cfg_data = 5'b11_111;
    reset = 1'b1;
    model_reset();
    #1;
    total_cnt++;
    if (step_cnt !== 8'd0) $display("FAIL async_step_cnt actual=%0d expected=0", step_cnt);
    else pass_cnt++;
    total_cnt++;
    if (state !== 2'd0) $display("FAIL async_state actual=%0d expected=0", state);
    else pass_cnt++;
    total_cnt++;
    if (out_s !== 3'b000) $display("FAIL async_out actual=%b expected=000", out_s);
    else pass_cnt++;
    @(negedge clk);
    run = 1'b0; in_valid = 1'b0; cfg_we = 1'b0;
    total_cnt++;
    if (out_s !== 3'b000) $display("FAIL async_write_discard actual=%b expected=000", out_s);
    else pass_cnt++;
    reset = 1'b0;
    // First write and step after release.
    write_entry(3'b000, 5'b01_101);
    #1;
    total_cnt++;
    if (out_s !== 3'b101) $display("FAIL post_reset_write actual=%b expected=101", out_s);
    else pass_cnt++;
    do_step(1'b0);
    total_cnt++;
    if (state !== 2'd1) $display("FAIL post_reset_step actual=%0d expected=1", state);
    else pass_cnt++;
    total_cnt++;
    if (step_cnt !== exp_cnt()) $display("FAIL post_reset_cnt actual=%0d expected=%0d", step_cnt, exp_cnt());
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_load();
    test_step_seq();
    test_gating();
    test_collision();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
